// File: rtl/bias_add_relu_pkg.sv
// Shared widths and FSM encoding for the bias/ReLU/requantise output stage.
package bias_add_relu_pkg;

  localparam int unsigned CNN_PARA_WIDTH = 16;
  localparam int unsigned CNN_ACC_WIDTH  = 32;
  localparam int unsigned CNN_OUT_WIDTH  = 16;
  localparam int unsigned CNN_ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/bias_sat_unit.sv
// Combinational bias add, optional ReLU, arithmetic rescale and saturation to OUT_WIDTH.
module bias_sat_unit
  import bias_add_relu_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = CNN_ACC_WIDTH,
  parameter int unsigned PARA_WIDTH = CNN_PARA_WIDTH,
  parameter int unsigned OUT_WIDTH  = CNN_OUT_WIDTH,
  parameter int unsigned BIAS_SHIFT = 8,
  parameter int unsigned OUT_SHIFT  = 8,
  parameter bit          RELU_EN    = 1'b1
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [PARA_WIDTH-1:0] bias,
  output logic [OUT_WIDTH-1:0]  act
);

  // One guard bit keeps the add exact for any in-range accumulator and aligned bias.
  localparam int unsigned SumWidth = ACC_WIDTH + 1;

  logic signed [SumWidth-1:0] acc_ext;
  logic signed [SumWidth-1:0] bias_sx;
  logic signed [SumWidth-1:0] bias_ext;
  logic signed [SumWidth-1:0] sum;
  logic signed [SumWidth-1:0] sum_relu;
  logic signed [SumWidth-1:0] shifted;
  logic                       sat_hi;
  logic                       sat_lo;

  always_comb begin
    acc_ext  = {acc[ACC_WIDTH-1], acc};
    bias_sx  = {{(SumWidth - PARA_WIDTH){bias[PARA_WIDTH-1]}}, bias};
    bias_ext = bias_sx <<< BIAS_SHIFT;
    sum      = acc_ext + bias_ext;
    sum_relu = (RELU_EN && sum[SumWidth-1]) ? '0 : sum;
    shifted  = sum_relu >>> OUT_SHIFT;

    // In range only when every bit above the output sign bit matches the sign.
    sat_hi = !shifted[SumWidth-1] && (|shifted[SumWidth-2:OUT_WIDTH-1]);
    sat_lo = shifted[SumWidth-1] && !(&shifted[SumWidth-2:OUT_WIDTH-1]);

    if (sat_hi) begin
      act = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    end else if (sat_lo) begin
      act = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
    end else begin
      act = shifted[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/bias_add_relu.sv
// Layer sequencer: fetches one bias per channel from bias_rom and streams quantised
// activations through a single-entry output register under valid/ready.
module bias_add_relu
  import bias_add_relu_pkg::*;
#(
  parameter int unsigned CH_NUM     = 16,
  parameter int unsigned PIX_NUM    = 64,
  parameter int unsigned ACC_WIDTH  = CNN_ACC_WIDTH,
  parameter int unsigned OUT_WIDTH  = CNN_OUT_WIDTH,
  parameter int unsigned BIAS_SHIFT = 8,
  parameter int unsigned OUT_SHIFT  = 8,
  parameter bit          RELU_EN    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rom_r_en,
  output logic [CNN_ADDR_WIDTH-1:0] rom_raddr,
  input  logic [CNN_PARA_WIDTH-1:0] rom_dout,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ACC_WIDTH-1:0]      in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic                      out_last
);

  localparam int unsigned PixWidth = (PIX_NUM > 1) ? $clog2(PIX_NUM) : 1;
  localparam logic [PixWidth-1:0] PixLast = PixWidth'(PIX_NUM - 1);
  localparam logic [CNN_ADDR_WIDTH-1:0] ChLast = CNN_ADDR_WIDTH'(CH_NUM - 1);

  state_e                    state;
  logic [CNN_ADDR_WIDTH-1:0] ch;
  logic [PixWidth-1:0]       pix;
  logic [CNN_PARA_WIDTH-1:0] bias_reg;
  logic [OUT_WIDTH-1:0]      act;
  logic                      in_hs;
  logic                      out_hs;

  bias_sat_unit #(
    .ACC_WIDTH  (ACC_WIDTH),
    .PARA_WIDTH (CNN_PARA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .BIAS_SHIFT (BIAS_SHIFT),
    .OUT_SHIFT  (OUT_SHIFT),
    .RELU_EN    (RELU_EN)
  ) u_sat (
    .acc  (in_data),
    .bias (bias_reg),
    .act  (act)
  );

  // The output register may refill in the same cycle it drains.
  assign in_ready  = (state == StRun) && (!out_valid || out_ready);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign rom_raddr = ch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      ch        <= '0;
      pix       <= '0;
      bias_reg  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_r_en  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      done     <= 1'b0;
      rom_r_en <= 1'b0;
      if (out_hs) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (start) begin
            state    <= StFetch;
            ch       <= '0;
            pix      <= '0;
            busy     <= 1'b1;
            rom_r_en <= 1'b1;
          end
        end
        StFetch: begin
          state <= StLatch;
        end
        StLatch: begin
          // The ROM output is only non-zero in the cycle after its enable.
          bias_reg <= rom_dout;
          state    <= StRun;
        end
        StRun: begin
          if (in_hs) begin
            out_valid <= 1'b1;
            out_data  <= act;
            out_last  <= (pix == PixLast);
            if (pix == PixLast) begin
              pix <= '0;
              if (ch < ChLast) begin
                ch       <= ch + CNN_ADDR_WIDTH'(1);
                state    <= StFetch;
                rom_r_en <= 1'b1;
              end else begin
                state <= StDone;
              end
            end else begin
              pix <= pix + PixWidth'(1);
            end
          end
        end
        StDone: begin
          if (!out_valid) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bias_add_relu.sv
// Randomised layer runs against an arithmetic reference, with a ReLU and a non-ReLU instance.
module tb_bias_add_relu;
  import bias_add_relu_pkg::*;

  localparam int unsigned CH  = 2;
  localparam int unsigned PIX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_data;
  logic [15:0] rom_dout;

  logic        busy, done, rom_r_en, in_ready, out_valid, out_last;
  logic [4:0]  rom_raddr;
  logic [15:0] out_data;
  logic        nr_busy, nr_done, nr_rom_r_en, nr_in_ready, nr_out_valid, nr_out_last;
  logic [4:0]  nr_rom_raddr;
  logic [15:0] nr_out_data;

  logic [15:0] bias_mem [CH];
  logic [31:0] in_q [$];
  logic [15:0] exp_q [$];
  logic [15:0] exp_nr_q [$];
  logic        exp_last_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bias_add_relu #(
    .CH_NUM (CH), .PIX_NUM (PIX), .ACC_WIDTH (32), .OUT_WIDTH (16),
    .BIAS_SHIFT (8), .OUT_SHIFT (8), .RELU_EN (1'b1)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .busy (busy), .done (done),
    .rom_r_en (rom_r_en), .rom_raddr (rom_raddr), .rom_dout (rom_dout),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data), .out_last (out_last)
  );

  bias_add_relu #(
    .CH_NUM (CH), .PIX_NUM (PIX), .ACC_WIDTH (32), .OUT_WIDTH (16),
    .BIAS_SHIFT (8), .OUT_SHIFT (8), .RELU_EN (1'b0)
  ) dut_nr (
    .clk (clk), .rst (rst), .start (start), .busy (nr_busy), .done (nr_done),
    .rom_r_en (nr_rom_r_en), .rom_raddr (nr_rom_raddr), .rom_dout (rom_dout),
    .in_valid (in_valid), .in_ready (nr_in_ready), .in_data (in_data),
    .out_valid (nr_out_valid), .out_ready (out_ready), .out_data (nr_out_data),
    .out_last (nr_out_last)
  );

  // bias_rom model: registered read, zero when not enabled.
  always @(posedge clk or posedge rst) begin
    if (rst) rom_dout <= '0;
    else rom_dout <= (rom_r_en && rom_raddr < 5'(CH)) ? bias_mem[rom_raddr[0]] : '0;
  end

  function automatic logic [15:0] ref_act(input logic [31:0] acc, input logic [15:0] bias,
                                          input bit relu);
    longint s;
    longint r;
    s = longint'($signed(acc)) + longint'($signed(bias)) * 256;
    if (relu && s < 0) s = 0;
    r = s >>> 8;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_values();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_rom_r_en", 32'(rom_r_en), 32'(0));
    check("rst_rom_raddr", 32'(rom_raddr), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
  endtask

  // mode 0: constant 0x100, 1: saturation corners, 2: random
  task automatic load_layer(input int mode);
    logic [31:0] d;
    in_q.delete(); exp_q.delete(); exp_nr_q.delete(); exp_last_q.delete();
    for (int c = 0; c < int'(CH); c++) begin
      for (int p = 0; p < int'(PIX); p++) begin
        if (mode == 0) d = 32'h0000_0100;
        else if (mode == 1) d = (c == 0) ? 32'h7FFF_0000 : 32'h8000_0000;
        else begin
          case ($urandom_range(0, 2))
            0: d = $urandom();
            1: d = $urandom_range(0, 32'h1FFFF) - 32'h10000;
            default: d = {{8{$urandom_range(0, 1) == 1}}, 24'($urandom())};
          endcase
        end
        in_q.push_back(d);
        exp_q.push_back(ref_act(d, bias_mem[c], 1'b1));
        exp_nr_q.push_back(ref_act(d, bias_mem[c], 1'b0));
        exp_last_q.push_back(p == int'(PIX) - 1);
      end
    end
  endtask

  // rdy_mode 0: always ready, 1: 1,0,0,1 pattern, 2: random. vld_mode 1 adds input gaps.
  task automatic run_layer(input int rdy_mode, input int vld_mode, input bit timing,
                           input int extra_start, input int abort_after);
    int cyc, n_in, n_done, n_rom, first_rdy, last_hs;
    bit hs_in, stalled, held_last, aborted;
    logic [15:0] held;
    cyc = 0; n_in = 0; n_done = 0; n_rom = 0; first_rdy = -1; last_hs = 0;
    hs_in = 0; stalled = 0; held_last = 0; aborted = 0; held = '0;
    in_valid = 1'b0;
    while (n_done == 0 && cyc < 1000 && !aborted) begin
      @(negedge clk);
      start = (cyc == 0) || (cyc == extra_start);
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (!(in_valid && !hs_in)) begin
        in_valid = (in_q.size() > 0) && (vld_mode == 0 || $urandom_range(0, 3) != 0);
        in_data  = in_valid ? in_q[0] : $urandom();
      end
      #4;
      if (timing && cyc == 1) check("busy_after_start", 32'(busy), 32'(1));
      if (rom_r_en) begin
        if (timing && n_rom == 0) check("rom_en_cycle", 32'(cyc), 32'(1));
        check("rom_raddr", 32'(rom_raddr), 32'(n_rom));
        check("nr_rom", 32'({nr_rom_r_en, nr_rom_raddr}), 32'({1'b1, 5'(n_rom)}));
        n_rom++;
      end
      if (in_ready && first_rdy < 0) begin
        first_rdy = cyc;
        if (timing) check("first_in_ready_cycle", 32'(cyc), 32'(3));
      end
      if (stalled) begin
        check("stall_data", 32'(out_data), 32'(held));
        check("stall_last", 32'(out_last), 32'(held_last));
      end
      stalled = out_valid && !out_ready;
      if (stalled) begin
        check("stall_in_ready", 32'(in_ready), 32'(0));
        held = out_data;
        held_last = out_last;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 32'(1), 32'(0));
        else begin
          check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
          check("out_last", 32'(out_last), 32'(exp_last_q[0]));
          check("nr_out_data", 32'(nr_out_data), 32'(exp_nr_q.pop_front()));
          check("nr_out_last", 32'({nr_out_valid, nr_out_last}), 32'({1'b1, exp_last_q.pop_front()}));
        end
      end
      hs_in = in_valid && in_ready;
      if (hs_in) begin
        check("nr_in_ready", 32'(nr_in_ready), 32'(1));
        if (timing && n_in == int'(PIX)) check("channel_bubble", 32'(cyc - last_hs), 32'(3));
        last_hs = cyc;
        void'(in_q.pop_front());
        n_in++;
        if (abort_after > 0 && n_in == abort_after) aborted = 1;
      end
      if (done) begin
        n_done++;
        check("busy_at_done", 32'(busy), 32'(0));
        check("nr_done", 32'({nr_done, nr_busy}), 32'({1'b1, 1'b0}));
      end
      cyc++;
    end
    if (!aborted) begin
      check("done_seen", 32'(n_done), 32'(1));
      check("beats_left", 32'(exp_q.size()), 32'(0));
      check("rom_reads", 32'(n_rom), 32'(CH));
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b0;
      #4;
      check("done_pulse_width", 32'(done), 32'(0));
      check("busy_after_done", 32'(busy), 32'(0));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    bias_mem[0] = '0; bias_mem[1] = '0;
    #12;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;

    // Basic add, plus start/bubble timing.
    bias_mem[0] = 16'h0010; bias_mem[1] = 16'hFFF0;
    load_layer(0);
    run_layer(0, 0, 1'b1, -1, 0);

    // Saturation corners on both instances.
    bias_mem[0] = 16'h7FFF; bias_mem[1] = 16'h8000;
    load_layer(1);
    run_layer(0, 0, 1'b1, -1, 0);

    // Backpressure 1,0,0,1 and random ready with random data.
    repeat (3) begin
      bias_mem[0] = 16'($urandom()); bias_mem[1] = 16'($urandom());
      load_layer(2);
      run_layer(1, 1, 1'b0, -1, 0);
    end
    repeat (2) begin
      bias_mem[0] = 16'($urandom()); bias_mem[1] = 16'($urandom());
      load_layer(2);
      run_layer(2, 1, 1'b0, -1, 0);
    end

    // A start during FETCH of channel 1 must be ignored.
    load_layer(2);
    run_layer(0, 0, 1'b1, 7, 0);

    // Reset in the middle of channel 1, then a clean layer from address 0.
    load_layer(2);
    run_layer(2, 1, 1'b0, -1, 6);
    @(posedge clk);
    #2;
    rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;
    bias_mem[0] = 16'($urandom()); bias_mem[1] = 16'($urandom());
    load_layer(2);
    run_layer(0, 0, 1'b1, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
